// File: rtl/mb_pkg.sv
// Shared constants and state encoding for the mean/binarize stage that follows
// the median filter engine.
package mb_pkg;

  localparam int ADDR_W = 14;
  localparam int PIX_W  = 8;
  localparam int SUM_W  = 22;
  localparam int N_PIX  = 1 << ADDR_W;

  localparam logic [7:0] PIX_ON  = 8'hFF;
  localparam logic [7:0] PIX_OFF = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    ACC,
    CALC,
    BIN,
    DRAIN,
    DONE
  } mb_state_e;

endpackage

// File: rtl/mean_binarize.sv
// Two passes over the filtered image: sum every pixel to get the global mean,
// then write a 0xFF/0x00 image thresholded strictly above that mean.
module mean_binarize #(
  parameter int ADDR_W = mb_pkg::ADDR_W,
  parameter int PIX_W  = mb_pkg::PIX_W,
  parameter int SUM_W  = mb_pkg::SUM_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  output logic              busy,
  output logic [ADDR_W-1:0] raddr,
  input  logic [PIX_W-1:0]  rdata,
  output logic [ADDR_W-1:0] waddr,
  output logic [PIX_W-1:0]  wdata,
  output logic              wen,
  output logic [PIX_W-1:0]  thr
);
  import mb_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  mb_state_e         state_q, state_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [PIX_W-1:0]  wdata_q, wdata_d;
  logic              wen_q, wen_d;
  logic [PIX_W-1:0]  thr_q, thr_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    raddr_d = raddr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wen_d   = 1'b0;
    thr_d   = thr_q;
    case (state_q)
      IDLE: begin
        if (ready) begin
          state_d = ACC;
          sum_d   = '0;
          raddr_d = '0;
        end
      end
      ACC: begin
        sum_d   = sum_q + SUM_W'(rdata);
        raddr_d = raddr_q + 1'b1;
        if (raddr_q == LAST_ADDR) state_d = CALC;
      end
      CALC: begin
        thr_d   = PIX_W'(sum_q >> ADDR_W);
        state_d = BIN;
      end
      BIN: begin
        wen_d   = 1'b1;
        waddr_d = raddr_q;
        wdata_d = (rdata > thr_q) ? PIX_W'(PIX_ON) : PIX_W'(PIX_OFF);
        raddr_d = raddr_q + 1'b1;
        if (raddr_q == LAST_ADDR) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        if (!ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // busy spans the whole run and is held one extra cycle past DRAIN so the
  // final write has fully settled before the next stage sees the falling edge
  assign busy_d = (state_d inside {ACC, CALC, BIN, DRAIN}) || (state_q == DRAIN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sum_q   <= '0;
      raddr_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      thr_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      raddr_q <= raddr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      thr_q   <= thr_d;
      busy_q  <= busy_d;
    end
  end

  assign busy  = busy_q;
  assign raddr = raddr_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign wen   = wen_q;
  assign thr   = thr_q;

endmodule
